// File: rtl/id_ex_stage_reg_if.sv
// ID/EX pipeline register bus.
// ID-side inputs and EX-side outputs in one bundle.
interface id_ex_stage_reg_if #(
  parameter int WIDTH  = 32,
  parameter int REG_AW = 5,
  parameter int CNT_W  = 32
);
  logic              hold;
  logic              flush;
  logic              id_valid;
  logic [5:0]        id_ctrl;
  logic [1:0]        id_ALUOp;
  logic [WIDTH-1:0]  id_rdata1;
  logic [WIDTH-1:0]  id_rdata2;
  logic [WIDTH-1:0]  id_imm;
  logic [WIDTH-1:0]  id_pc4;
  logic [REG_AW-1:0] id_rs;
  logic [REG_AW-1:0] id_rt;
  logic [REG_AW-1:0] id_rd;

  logic              ex_valid;
  logic [5:0]        ex_ctrl;
  logic [1:0]        ex_ALUOp;
  logic [5:0]        ex_funct;
  logic [WIDTH-1:0]  ex_rdata1;
  logic [WIDTH-1:0]  ex_rdata2;
  logic [WIDTH-1:0]  ex_imm;
  logic [WIDTH-1:0]  ex_pc4;
  logic [REG_AW-1:0] ex_rs;
  logic [REG_AW-1:0] ex_rt;
  logic [REG_AW-1:0] ex_rd;
  logic [CNT_W-1:0]  bubble_count;

  modport master (
    output hold, flush, id_valid, id_ctrl, id_ALUOp,
    output id_rdata1, id_rdata2, id_imm, id_pc4,
    output id_rs, id_rt, id_rd,
    input  ex_valid, ex_ctrl, ex_ALUOp, ex_funct,
    input  ex_rdata1, ex_rdata2, ex_imm, ex_pc4,
    input  ex_rs, ex_rt, ex_rd, bubble_count
  );

  modport slave (
    input  hold, flush, id_valid, id_ctrl, id_ALUOp,
    input  id_rdata1, id_rdata2, id_imm, id_pc4,
    input  id_rs, id_rt, id_rd,
    output ex_valid, ex_ctrl, ex_ALUOp, ex_funct,
    output ex_rdata1, ex_rdata2, ex_imm, ex_pc4,
    output ex_rs, ex_rt, ex_rd, bubble_count
  );
endinterface

// File: rtl/id_ex_stage_reg.sv
// ID/EX pipeline register with hold, flush
// and a bubble counter for CPI statistics.
module id_ex_stage_reg #(
  parameter int WIDTH  = 32,
  parameter int REG_AW = 5,
  parameter int CNT_W  = 32
) (
  input logic              clk,
  input logic              reset,
  id_ex_stage_reg_if.slave bus
);
  typedef struct packed {
    logic [WIDTH-1:0]  rdata1;
    logic [WIDTH-1:0]  rdata2;
    logic [WIDTH-1:0]  imm;
    logic [WIDTH-1:0]  pc4;
    logic [REG_AW-1:0] rs;
    logic [REG_AW-1:0] rt;
    logic [REG_AW-1:0] rd;
  } data_t;

  logic             valid_q, valid_d;
  logic [5:0]       ctrl_q, ctrl_d;
  logic [1:0]       aluop_q, aluop_d;
  data_t            data_q, data_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  data_t            id_data;

  assign id_data = '{
    rdata1: bus.id_rdata1,
    rdata2: bus.id_rdata2,
    imm:    bus.id_imm,
    pc4:    bus.id_pc4,
    rs:     bus.id_rs,
    rt:     bus.id_rt,
    rd:     bus.id_rd
  };

  // Next state: flush beats hold; a bubble
  // always carries zero control.
  always_comb begin
    valid_d = valid_q;
    ctrl_d  = ctrl_q;
    aluop_d = aluop_q;
    data_d  = data_q;
    cnt_d   = cnt_q;
    if (bus.flush) begin
      valid_d = 1'b0;
      ctrl_d  = '0;
      aluop_d = '0;
      data_d  = id_data;
      cnt_d   = cnt_q + 1'b1;
    end else if (!bus.hold) begin
      valid_d = bus.id_valid;
      ctrl_d  = bus.id_valid ? bus.id_ctrl : '0;
      aluop_d = bus.id_valid ? bus.id_ALUOp : '0;
      data_d  = id_data;
      if (!bus.id_valid) cnt_d = cnt_q + 1'b1;
    end
  end

  // State register with synchronous reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      valid_q <= 1'b0;
      ctrl_q  <= '0;
      aluop_q <= '0;
      data_q  <= '0;
      cnt_q   <= '0;
    end else begin
      valid_q <= valid_d;
      ctrl_q  <= ctrl_d;
      aluop_q <= aluop_d;
      data_q  <= data_d;
      cnt_q   <= cnt_d;
    end
  end

  assign bus.ex_valid     = valid_q;
  assign bus.ex_ctrl      = ctrl_q;
  assign bus.ex_ALUOp     = aluop_q;
  assign bus.ex_rdata1    = data_q.rdata1;
  assign bus.ex_rdata2    = data_q.rdata2;
  assign bus.ex_imm       = data_q.imm;
  assign bus.ex_funct     = data_q.imm[5:0];
  assign bus.ex_pc4       = data_q.pc4;
  assign bus.ex_rs        = data_q.rs;
  assign bus.ex_rt        = data_q.rt;
  assign bus.ex_rd        = data_q.rd;
  assign bus.bubble_count = cnt_q;
endmodule

// File: doc/id_ex_stage_reg.md
Name: id_ex_stage_reg

Overview:
ID/EX pipeline register feeding the EX stage of the 5-stage MIPS core. Captures decoded control (incl. the 2-bit ALUOp), register operands, immediate, PC+4 and register specifiers at each clock edge. Presents ALUOp and funct to the EX-stage ALU control decoder. Supports hazard-unit hold and flush, and keeps a bubble counter for CPI statistics.

Parameters:
WIDTH, 32, datapath width of operands, immediate and PC+4
REG_AW, 5, register specifier width
CNT_W, 32, bubble counter width

Ports:
clk  in  1  pipeline clock, all state updates on rising edge
reset  in  1  synchronous, active-high reset
hold  in  1  stall: keep current contents (hazard unit)
flush  in  1  insert bubble: zero control and valid (load-use stall or branch squash)
id_valid  in  1  ID stage holds a real instruction
id_ctrl  in  6  {RegWrite, MemtoReg, MemRead, MemWrite, RegDst, ALUSrc}
id_ALUOp  in  2  00 add (lw/sw), 01 sub (beq), 10 R-type by funct, 11 and
id_rdata1  in  WIDTH  register file read port 1 (rs)
id_rdata2  in  WIDTH  register file read port 2 (rt)
id_imm  in  WIDTH  sign-extended immediate
id_pc4  in  WIDTH  PC+4 of the instruction
id_rs  in  REG_AW  rs specifier
id_rt  in  REG_AW  rt specifier
id_rd  in  REG_AW  rd specifier
ex_valid  out  1  EX holds a real instruction
ex_ctrl  out  6  registered id_ctrl, same bit order
ex_ALUOp  out  2  registered ALUOp, to ALU control
ex_funct  out  6  ex_imm[5:0], to ALU control
ex_rdata1  out  WIDTH  registered operand A
ex_rdata2  out  WIDTH  registered operand B / store data
ex_imm  out  WIDTH  registered immediate
ex_pc4  out  WIDTH  registered PC+4
ex_rs  out  REG_AW  registered rs (forwarding unit)
ex_rt  out  REG_AW  registered rt (forwarding unit, RegDst mux)
ex_rd  out  REG_AW  registered rd (RegDst mux)
bubble_count  out  CNT_W  number of bubbles entered into EX since reset

Behaviour:
- Priority per rising edge: reset > flush > hold > load.
- reset=1: every registered output 0 (ex_valid=0, ex_ctrl=0, ex_ALUOp=00, all data/specifier fields 0); bubble_count=0. ex_funct therefore 0. Reset mid-stream discards the in-flight instruction, with no partial update.
- flush=1 (reset=0): ex_valid<=0, ex_ctrl<=0, ex_ALUOp<=00. Data, immediate, pc4 and specifier fields load from ID (don't-care values, loaded to keep muxing simple). Takes effect even when hold=1.
- hold=1, flush=0: all registers keep their value and bubble_count is unchanged.
- Load (no reset/flush/hold): all fields <= ID inputs. When id_valid=0, ex_ctrl and ex_ALUOp are forced to 0 while data fields load normally.
- Bubble accounting: bubble_count += 1 on any non-reset edge that writes ex_valid<=0, i.e. flush, or a load with id_valid=0. It wraps from all-ones to 0 with no saturation. Hold cycles do not count.
- Latency: exactly 1 cycle ID->EX. Outputs are purely registered, except ex_funct, which is a direct wire slice of ex_imm.
- Invariant: ex_valid=0 implies ex_ctrl=0 and ex_ALUOp=00, so a bubble cannot write the register file or memory.
- No combinational path from any input to any output.

Test Plan:
- Reset: drive reset=1 for 2 cycles with arbitrary ID inputs -> all outputs 0, bubble_count=0. Then release with id_valid=1, id_ctrl=6'b100011, id_ALUOp=10, id_imm=32'h0000_0020 -> next edge ex_ctrl=100011, ex_ALUOp=10, ex_funct=6'h20, ex_valid=1.
- Streaming: apply 4 distinct instructions on consecutive cycles (rdata1 = 1,2,3,4) -> ex_rdata1 shows 1,2,3,4 one cycle later each, bubble_count stays 0.
- Hold: load rdata1=32'hDEADBEEF, then hold=1 for 3 cycles while ID changes -> ex_rdata1 stays DEADBEEF and bubble_count is unchanged. Release hold -> the new ID value loads on the next edge.
- Flush and hold together: hold=1 and flush=1 with id_ctrl=111111 -> ex_valid=0, ex_ctrl=0, ex_ALUOp=00, bubble_count increments by 1.
- id_valid=0 load, with id_ctrl=6'b111111 and id_ALUOp=11 -> ex_ctrl=0, ex_ALUOp=00, ex_valid=0, bubble_count+1.
- Wrap and reset: with CNT_W=4, issue 17 flushes -> bubble_count reads 1. Assert reset together with flush -> bubble_count=0 and all outputs 0.
